sub_bytes_128_seq: RTL and testbench
====================================

// Module: sub_bytes_128_seq
// PURPOSE
// - Forward AES SubBytes over a full 128-bit state; encryption-side counterpart of the 16-lane inverse substitution.
// - Iterative: LANES S-box lookups per cycle, 16/LANES passes per block, valid/ready on both sides.
// - Sits between AddRoundKey and ShiftRows in the encrypt round datapath.
// PARAMETERS
// - LANES  4  S-box instances used per cycle; legal values 1,2,4,8,16; PASSES = 16/LANES.
// PORTS
// - clk        in   1    system clock, all state updates on posedge
// - reset_n    in   1    asynchronous, active-low reset
// - in_valid   in   1    state_in valid
// - in_ready   out  1    block can accept state_in
// - state_in   in   128  input state; byte k = state_in[8k+7:8k], k=0..15
// - out_valid  out  1    state_out valid
// - out_ready  in   1    downstream accepts state_out
// - state_out  out  128  substituted state, same byte mapping as state_in
// - busy       out  1    high in RUN or DONE
// BEHAVIOUR
// - One clock (clk); reset_n asynchronous assert, active-low; released synchronously by the integrating top.
// - S-box: FIPS-197 forward table, combinational lookup feeding work register; the output path has no negedge registers.
// - FSM states IDLE, RUN, DONE; reset -> IDLE, work=0, cnt=0, out_valid=0, busy=0, in_ready=1.
// - IDLE: in_ready=1. On in_valid at posedge: work<=state_in, cnt<=0, -> RUN.
// - RUN: in_ready=0. Each posedge: work bytes k in [cnt*LANES, cnt*LANES+LANES-1] <= S(work byte k).
//   All other bytes hold. cnt<=cnt+1. When cnt==PASSES-1, that same edge -> DONE.
// - DONE: out_valid=1, state_out=work, stable until out_valid&&out_ready at posedge -> IDLE.
// - state_out = work in every state; only qualified by out_valid.
// - Latency: accept edge E; out_valid high after edge E+PASSES (LANES=4: 4 cycles; LANES=16: 1 cycle).
// - Throughput: in_ready only in IDLE. Min cycles/block = PASSES+2 with out_ready held high.
// - in_valid while not in_ready: ignored, no capture, no error.
// - out_ready low in DONE: hold indefinitely. out_ready high outside DONE: no effect.
// - cnt width = max(1,$clog2(PASSES)). LANES=16: RUN lasts exactly one cycle.
// - reset_n low mid-RUN or mid-DONE: immediate return to reset values, partial result discarded, no out_valid.
// - Each byte is substituted exactly once per block; no byte is skipped or double-substituted for any legal LANES.
// TESTING
// - Reset: assert reset_n=0 mid-RUN -> out_valid=0, in_ready=1, busy=0 at once; no out_valid after release.
// - Zero state: state_in=0 -> state_out=128'h6363...63 (16x 63), out_valid 4 cycles after accept (LANES=4).
// - Known vector: state_in=128'h0f0e0d0c0b0a09080706050403020100
//   -> state_out=128'h76abd7fe2b670130c56f6bf27b777c63.
// - Backpressure: out_ready=0 for 10 cycles in DONE -> state_out and out_valid stable, in_ready=0; new in_valid ignored.
//   Release out_ready -> IDLE next cycle.
// - Sweep: 256 blocks, all 16 bytes = i for i=0..255 -> every byte = S(i); check 53->ED, FF->16.
//   Apply bench inverse S-box -> original state.
// - Parameter sweep LANES=1,2,8,16 -> identical results to LANES=4; latency = 16,8,2,1 cycles.
//   Back-to-back blocks with out_ready=1 spaced PASSES+2 cycles.

Source files
------------

// File: rtl/sub_bytes_128_seq.sv
// Iterative forward AES SubBytes over a 128-bit state.
// LANES S-box lookups per cycle, 16/LANES passes per block, valid/ready on both sides.
module sub_bytes_128_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int unsigned NBYTES = 16;
  localparam int unsigned PASSES = NBYTES / LANES;
  localparam int unsigned CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned LAST   = PASSES - 1;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // FIPS-197 forward S-box, entry n at index n
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NBYTES-1:0][7:0]   work_q, work_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;

  logic [IDX_W-1:0]         lane_idx [LANES];
  logic [7:0]               lane_sub [LANES];

  // Byte window handled this pass and its S-box lookups
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx[l] = IDX_W'(32'(cnt_q) * LANES + l);
      lane_sub[l] = SBOX[work_q[lane_idx[l]]];
    end
  end

  // State, pass counter, work register and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: capture in IDLE, substitute one window per RUN cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          work_d[lane_idx[l]] = lane_sub[l];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the handshake flops track the FSM
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = work_q;

endmodule

// File: tb/tb_sub_bytes_128_seq.sv
// Bench for sub_bytes_128_seq: five instances (LANES=1,2,4,8,16) share one stimulus stream.
module tb_sub_bytes_128_seq;

  localparam int NI  = 5;
  localparam int REF = 2;  // LANES=4 instance

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] state_in;
  logic         rdy [NI];
  logic         ov  [NI];
  logic         bsy [NI];
  logic [127:0] so  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_128_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .state_in  (state_in),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .state_out (so[g]),
      .busy      (bsy[g])
    );
  end

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] s_fwd [256];
  logic [7:0] s_inv [256];

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [6];

  // GF(2^8) arithmetic for the bench reference S-box
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] a);
    logic [7:0] inv, s;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s_inv[x[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_all_ready();
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < NI; i++) ok = ok & rdy[i];
      n++;
    end
    if (!ok) chk("idle_timeout", 128'(ok), 128'd1);
  endtask

  // One block through all instances; check latency, data and inverse round trip
  task automatic run_block(input string name, input logic [127:0] din, input logic [127:0] exp);
    int           lat [NI];
    logic [127:0] got [NI];
    wait_all_ready();
    in_valid = 1'b1;
    state_in = din;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0;
      got[i] = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (ov[i] && lat[i] == 0) begin
          lat[i] = c;
          got[i] = so[i];
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_lat_L%0d", name, 1 << i), 128'(lat[i]), 128'(16 >> i));
      chk($sformatf("%s_data_L%0d", name, 1 << i), got[i], exp);
    end
    chk($sformatf("%s_inverse", name), inv_state(got[REF]), din);
  endtask

  initial begin
    bit           seen;
    int           prev [NI];
    int           npulse [NI];
    logic [127:0] ones;

    for (int i = 0; i < 256; i++) s_fwd[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) s_inv[s_fwd[i]] = 8'(i);

    vecs[0] = '{"known",   128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63};
    vecs[1] = '{"zero",    128'h0,                                {16{8'h63}}};
    vecs[2] = '{"rev",     128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[3] = '{"all53",   {16{8'h53}},                           {16{8'hed}}};
    vecs[4] = '{"allff",   {16{8'hff}},                           {16{8'h16}}};
    vecs[5] = '{"all01",   {16{8'h01}},                           {16{8'h7c}}};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_in_ready_L%0d", 1 << i), 128'(rdy[i]), 128'd1);
      chk($sformatf("rst_out_valid_L%0d", 1 << i), 128'(ov[i]), 128'd0);
      chk($sformatf("rst_busy_L%0d", 1 << i), 128'(bsy[i]), 128'd0);
      chk($sformatf("rst_state_L%0d", 1 << i), so[i], 128'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int v = 0; v < 6; v++) run_block(vecs[v].name, vecs[v].din, vecs[v].exp);

    // Reset asserted mid-RUN discards the block
    wait_all_ready();
    in_valid = 1'b1;
    state_in = vecs[0].din;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_busy", 128'(bsy[REF]), 128'd1);
    chk("midrun_in_ready", 128'(rdy[REF]), 128'd0);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("arst_out_valid_L%0d", 1 << i), 128'(ov[i]), 128'd0);
      chk($sformatf("arst_in_ready_L%0d", 1 << i), 128'(rdy[i]), 128'd1);
      chk($sformatf("arst_busy_L%0d", 1 << i), 128'(bsy[i]), 128'd0);
      chk($sformatf("arst_state_L%0d", 1 << i), so[i], 128'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) seen = seen | ov[i];
    end
    chk("arst_no_out_valid", 128'(seen), 128'd0);

    // Backpressure in DONE: output held, new input ignored
    wait_all_ready();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = vecs[0].din;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1 seen = ov[REF];
    end
    chk("bp_reach_done", 128'(seen), 128'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      state_in = {4{$urandom}};
      @(posedge clk);
      #1;
      chk("bp_out_valid", 128'(ov[REF]), 128'd1);
      chk("bp_in_ready", 128'(rdy[REF]), 128'd0);
      chk("bp_state_out", so[REF], vecs[0].exp);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 128'(ov[REF]), 128'd0);
    chk("bp_release_in_ready", 128'(rdy[REF]), 128'd1);

    // Back-to-back blocks with in_valid and out_ready held high
    wait_all_ready();
    state_in = '0;
    in_valid = 1'b1;
    for (int i = 0; i < NI; i++) begin
      prev[i]   = -1;
      npulse[i] = 0;
    end
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (ov[i]) begin
          if (prev[i] >= 0)
            chk($sformatf("b2b_spacing_L%0d", 1 << i), 128'(c - prev[i]), 128'((16 >> i) + 2));
          chk($sformatf("b2b_data_L%0d", 1 << i), so[i], {16{8'h63}});
          prev[i] = c;
          npulse[i]++;
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++)
      chk($sformatf("b2b_count_L%0d", 1 << i), 128'(npulse[i] >= 3), 128'd1);

    // Sweep: every byte equal to i
    for (int i = 0; i < 256; i++) begin
      ones = {16{8'(i)}};
      run_block($sformatf("sweep%02h", i), ones, {16{s_fwd[i]}});
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
